// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides
module booth_seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int N  = WIDTH / 2 + 1;
    localparam int CW = $clog2(N + 1);
    localparam int PW = 2 * WIDTH + 4;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [PW-1:0]      m_q, acc_q, acc_d, pp;
    logic [WIDTH+2:0]   b_q;
    logic [2*WIDTH-1:0] product_q;
    logic [WIDTH+1:0]   a_ext, b_ext;
    logic [2:0]         digit;
    logic               last;
    assign last  = cnt_q == CW'(N - 1);
    assign a_ext = is_signed ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
    assign b_ext = is_signed ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};
    assign digit = b_q[2:0];
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    // next state: accept in IDLE, N digit steps in CALC, hold in DONE until consumed
    always_comb begin
        state_d = (state_q == IDLE && in_valid)  ? CALC :
                  (state_q == CALC && last)      ? DONE :
                  (state_q == DONE && out_ready) ? IDLE : state_q;
    end
    // handshake outputs decoded from state
    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
        busy      = state_q != IDLE;
        product   = product_q;
    end
    // Booth digit decode; m_q already carries the 4^i weight of the current digit
    always_comb begin
        pp    = (digit == 3'b001 || digit == 3'b010) ? m_q :
                (digit == 3'b011)                    ? (m_q << 1) :
                (digit == 3'b100)                    ? -(m_q << 1) :
                (digit == 3'b101 || digit == 3'b110) ? -m_q : '0;
        acc_d = acc_q + pp;
    end
    // datapath: latch extended operands on accept, then accumulate and shift per digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else if (state_q == IDLE && in_valid) begin
            m_q   <= {{(PW - WIDTH - 2){a_ext[WIDTH+1]}}, a_ext};
            b_q   <= {b_ext, 1'b0};
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == CALC) begin
            m_q   <= m_q << 2;
            b_q   <= b_q >> 2;
            acc_q <= acc_d;
            cnt_q <= cnt_q + CW'(1);
            if (last) product_q <= acc_d[2*WIDTH-1:0];
        end
    end
endmodule
